pc_fetch: RTL and testbench

- Front-end stage of the multi-cycle MIPS core.
- Owns the architectural PC and fetches one instruction at a time over the instruction-memory valid/ready handshake.
- Hands the instruction and PC+4 to decode/branch-target logic.
- Waits for the next-PC decision (taken flag plus 32-bit target) from the downstream target stage, then updates PC.

---
 rtl/pc_fetch.sv | 125 ++++++++++++
 tb/tb_pc_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: MIPS front end; owns the PC and fetches one instruction per pass over a valid/ready memory handshake.
// Latency: 4 cycles per instruction minimum (IF, IW, DH, WP), with each extra cycle of handshake wait adding to that.
// Backpressure: each stage holds its state and outputs until its partner handshakes. A misaligned taken target halts the block until rst.
// Optional build macro FETCH_PERF_CNT_EN adds a completed-fetch counter. Without it, fetch_count is tied to zero.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ack,
    output logic [31:0] PC,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    input  logic [31:0] Instruction,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_next,
    input  logic        pc_update_valid,
    input  logic        pc_taken,
    input  logic [31:0] pc_target,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IF   = 3'd1,
        ST_IW   = 3'd2,
        ST_DH   = 3'd3,
        ST_WP   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;

    // The sequential successor address is always visible, so decode sees it stable for the whole pass.
    assign pc_next     = pc_q + 32'd4;
    assign PC          = pc_q;
    assign instr       = instr_q;
    assign fetch_err   = err_q;

    // State and datapath registers; reset abandons any handshake in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic plus Moore handshake outputs. Each partner input is honoured only in its own state.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        err_d          = err_q;
        Inst_Req_Valid = 1'b0;
        Inst_Ready     = 1'b0;
        instr_valid    = 1'b0;
        case (state_q)
            ST_INIT: state_d = ST_IF;
            ST_IF: begin
                Inst_Req_Valid = 1'b1;
                // A word that arrives together with the ack is dropped. Memory must present it again in IW.
                if (Inst_Req_Ack) state_d = ST_IW;
            end
            ST_IW: begin
                Inst_Ready = 1'b1;
                if (Inst_Valid) begin
                    instr_d = Instruction;
                    state_d = ST_DH;
                end
            end
            ST_DH: begin
                instr_valid = 1'b1;
                if (instr_ready) state_d = ST_WP;
            end
            ST_WP: begin
                if (pc_update_valid) begin
                    if (pc_taken && (pc_target[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_taken ? pc_target : pc_next;
                        state_d = ST_IF;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_INIT;
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] count_q, count_d;

    // Count each captured instruction word; the counter wraps naturally at 2^32.
    always_comb begin
        count_d = count_q;
        if ((state_q == ST_IW) && Inst_Valid) count_d = count_q + 32'd1;
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= 32'h0;
        else     count_q <= count_d;
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch. It runs two instances: one with the default reset PC, and one that starts at the top of the address space.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Expected values are hand-computed constants.
module tb_pc_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_vld, req_ack, ivalid, irdy, instr_vld, instr_rdy;
    logic        upd_vld, taken, err;
    logic [31:0] pc, idata, instr_o, pcn, target, fcnt;

    logic        b_req_vld, b_irdy, b_instr_vld, b_err;
    logic [31:0] b_pc, b_instr, b_pcn, b_fcnt;

    int checks = 0;
    int errors = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk(clk), .rst(rst),
        .Inst_Req_Valid(req_vld), .Inst_Req_Ack(req_ack), .PC(pc),
        .Inst_Valid(ivalid), .Inst_Ready(irdy), .Instruction(idata),
        .instr(instr_o), .instr_valid(instr_vld), .instr_ready(instr_rdy),
        .pc_next(pcn), .pc_update_valid(upd_vld), .pc_taken(taken),
        .pc_target(target), .fetch_err(err), .fetch_count(fcnt)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
        .clk(clk), .rst(rst),
        .Inst_Req_Valid(b_req_vld), .Inst_Req_Ack(1'b1), .PC(b_pc),
        .Inst_Valid(1'b1), .Inst_Ready(b_irdy), .Instruction(32'h0000_0000),
        .instr(b_instr), .instr_valid(b_instr_vld), .instr_ready(1'b1),
        .pc_next(b_pcn), .pc_update_valid(1'b1), .pc_taken(1'b0),
        .pc_target(32'h0000_0002), .fetch_err(b_err), .fetch_count(b_fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake outputs packed as {Inst_Req_Valid, Inst_Ready, instr_valid}.
    function automatic logic [31:0] hs();
        return {29'h0, req_vld, irdy, instr_vld};
    endfunction

    initial begin
        req_ack = 1'b0; ivalid = 1'b0; idata = 32'h0; instr_rdy = 1'b0;
        upd_vld = 1'b0; taken = 1'b0; target = 32'h0;
        step(); step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_hs", hs(), 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_cnt", fcnt, 32'h0);
        chk("top_rst_pc", b_pc, 32'hFFFF_FFFC);

        // Zero-wait partners, not-taken loop.
        req_ack = 1'b1; ivalid = 1'b1; idata = 32'h2408_0001;
        instr_rdy = 1'b1; upd_vld = 1'b1; taken = 1'b0;
        rst = 1'b0;
        step();                                   // INIT -> IF
        chk("if0_hs", hs(), 32'h4);
        chk("if0_pc", pc, 32'h0);
        chk("top_if_pcnext", b_pcn, 32'h0);
        step();                                   // IW
        chk("iw0_hs", hs(), 32'h2);
        step();                                   // DH
        chk("dh0_hs", hs(), 32'h1);
        chk("dh0_instr", instr_o, 32'h2408_0001);
        chk("dh0_pcnext", pcn, 32'h4);
        step();                                   // WP
        chk("wp0_hs", hs(), 32'h0);
        chk("wp0_pc", pc, 32'h0);
        step();                                   // IF again: 4-cycle loop
        chk("if1_hs", hs(), 32'h4);
        chk("if1_pc", pc, 32'h4);
        chk("top_wrap_pc", b_pc, 32'h0);
        chk("top_wrap_hs", {31'h0, b_req_vld}, 32'h1);

        // Three more sequential loops bring the PC to 0x10.
        for (int i = 0; i < 3; i++) begin
            step(); step(); step(); step();
        end
        chk("if_pc10", pc, 32'h10);

        // Taken branch to 0x40.
        taken = 1'b1; target = 32'h40;
        step(); step(); step(); step();
        chk("taken_pc", pc, 32'h40);
        chk("taken_hs", hs(), 32'h4);
        chk("cnt5", fcnt, CNT_ON ? 32'd5 : 32'd0);
        taken = 1'b0;

        // The ack stalls for 3 cycles, while a spurious word is offered in IF.
        req_ack = 1'b0; ivalid = 1'b1; idata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_if_hs", hs(), 32'h4);
            chk("stall_if_pc", pc, 32'h40);
            chk("stall_if_instr", instr_o, 32'h2408_0001);
        end
        req_ack = 1'b1;                           // ack with data present: only ack taken
        step();
        chk("ack_iw_hs", hs(), 32'h2);
        chk("ack_iw_instr", instr_o, 32'h2408_0001);
        ivalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_iw_hs", hs(), 32'h2);
            chk("stall_iw_instr", instr_o, 32'h2408_0001);
        end
        ivalid = 1'b1; idata = 32'h8C09_0004;
        step();
        chk("cap_dh_hs", hs(), 32'h1);
        chk("cap_instr", instr_o, 32'h8C09_0004);
        chk("cap_pcnext", pcn, 32'h44);

        // Hold in WP while the next-PC decision is not valid.
        upd_vld = 1'b0;
        step();                                   // WP
        step();
        chk("wp_hold_hs", hs(), 32'h0);
        chk("wp_hold_pc", pc, 32'h40);
        upd_vld = 1'b1;
        step();
        chk("wp_go_pc", pc, 32'h44);

        // A misaligned target that is not taken is harmless.
        taken = 1'b0; target = 32'h42;
        step(); step(); step(); step();
        chk("nt_mis_pc", pc, 32'h48);
        chk("nt_mis_err", {31'h0, err}, 32'h0);

        // A misaligned target that is taken halts the core.
        taken = 1'b1;
        step(); step(); step(); step();
        chk("halt_err", {31'h0, err}, 32'h1);
        chk("halt_pc", pc, 32'h48);
        chk("halt_hs", hs(), 32'h0);
        chk("cnt8", fcnt, CNT_ON ? 32'd8 : 32'd0);
        step(); step(); step();
        chk("halt_stay_hs", hs(), 32'h0);
        chk("halt_stay_err", {31'h0, err}, 32'h1);
        taken = 1'b0;

        // Reset is the only way out of HALT; it acts asynchronously.
        rst = 1'b1;
        #1;
        chk("rst2_err", {31'h0, err}, 32'h0);
        chk("rst2_pc", pc, 32'h0);
        step();
        rst = 1'b0;
        step(); step(); step(); step(); step();   // INIT IF IW DH WP
        step();                                   // IF, pc=4
        ivalid = 1'b0;
        step();                                   // IW, waiting
        chk("pre_rst_iw", hs(), 32'h2);
        chk("pre_rst_cnt", fcnt, CNT_ON ? 32'd1 : 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_hs", hs(), 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instr", instr_o, 32'h0);
        chk("midrst_cnt", fcnt, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
